softsw_status_tx: RTL and testbench

- Reverse path of the MCU soft-switch command channel: reports FPGA-side switch state back to the MCU as 16-bit words {index[7:0], value[7:0]}.
- Uses the same index map and value encoding the MCU uses for its soft-switch commands.
- Watches 14 switch fields, which may change from hotkeys or port writes. Each changed field is marked pending and sent one word at a time over a valid/ready handshake into the MCU SPI transmit path.
- A resync pulse requests a full state dump.

---
 rtl/softsw_pkg.sv | 54 +++++
 rtl/softsw_status_tx_rr_pick.sv | 48 ++++
 rtl/softsw_status_tx.sv | 154 +++++++++++++++
 tb/tb_softsw_status_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/softsw_pkg.sv
// softsw_pkg
// Soft-switch field map shared by the MCU command-decode side and the
// status-report side, so both directions agree on one index/width table.
// Words on the wire are {index[7:0], value[7:0]}, value zero-extended.
package softsw_pkg;

  localparam int NUM_FIELDS = 14;
  localparam int IDX_W      = 8;
  localparam int VAL_W      = 8;

  // Field indices
  localparam logic [IDX_W-1:0] IDX_ROM_BANK      = 8'h00;
  localparam logic [IDX_W-1:0] IDX_TURBOFDC      = 8'h01;
  localparam logic [IDX_W-1:0] IDX_COVOX_EN      = 8'h02;
  localparam logic [IDX_W-1:0] IDX_PSG_MIX       = 8'h03;
  localparam logic [IDX_W-1:0] IDX_PSG_TYPE      = 8'h04;
  localparam logic [IDX_W-1:0] IDX_VIDEO_15KHZ   = 8'h05;
  localparam logic [IDX_W-1:0] IDX_TURBO         = 8'h06;
  localparam logic [IDX_W-1:0] IDX_SWAP_FDD      = 8'h07;
  localparam logic [IDX_W-1:0] IDX_JOY_TYPE      = 8'h08;
  localparam logic [IDX_W-1:0] IDX_NEMOIDE_EN    = 8'h09;
  localparam logic [IDX_W-1:0] IDX_KEYBOARD_TYPE = 8'h0A;
  localparam logic [IDX_W-1:0] IDX_PAUSE         = 8'h0B;
  localparam logic [IDX_W-1:0] IDX_NMI           = 8'h0C;
  localparam logic [IDX_W-1:0] IDX_SYS_RESET     = 8'h0D;

  // Field widths in bits
  localparam int W_ROM_BANK      = 2;
  localparam int W_TURBOFDC      = 1;
  localparam int W_COVOX_EN      = 1;
  localparam int W_PSG_MIX       = 2;
  localparam int W_PSG_TYPE      = 1;
  localparam int W_VIDEO_15KHZ   = 1;
  localparam int W_TURBO         = 2;
  localparam int W_SWAP_FDD      = 1;
  localparam int W_JOY_TYPE      = 3;
  localparam int W_NEMOIDE_EN    = 1;
  localparam int W_KEYBOARD_TYPE = 1;
  localparam int W_PAUSE         = 1;
  localparam int W_NMI           = 1;
  localparam int W_SYS_RESET     = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  function automatic logic [IDX_W+VAL_W-1:0] make_word(input logic [IDX_W-1:0] idx,
                                                       input logic [VAL_W-1:0] val);
    return {idx, val};
  endfunction

endpackage

// File: rtl/softsw_status_tx_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Returns the first set bit of i_pending
// searching i_ptr+1, i_ptr+2, ... with wrap from N-1 to 0 (i_ptr itself is
// checked last).
// Ports:
//   i_pending  N     request vector
//   i_ptr      IW    last granted index (must be < N)
//   o_any      1     at least one request set
//   o_idx      IW    granted index (0 when o_any is low)
module rr_pick
  import softsw_pkg::*;
#(
  parameter int N  = NUM_FIELDS,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW-1:0] w_cand [N];
  logic [N-1:0]  w_hit;

  // Candidate gi is the index at distance gi+1 after the pointer. One extra
  // bit on the sum keeps ptr+offset (< 2N) from overflowing before the wrap.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] w_sum;
    assign w_sum       = {1'b0, i_ptr} + (IW+1)'(gi + 1);
    assign w_cand[gi]  = (w_sum >= N_EXT) ? IW'(w_sum - N_EXT) : w_sum[IW-1:0];
    assign w_hit[gi]   = i_pending[w_cand[gi]];
  end

  assign o_any = |i_pending;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_idx = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/softsw_status_tx.sv
// softsw_status_tx
// Reports FPGA-side soft-switch state to the MCU as 16-bit words
// {index, value}. Every field is snapshotted each cycle; a difference marks
// the field pending. Pending fields are sent one per word, round-robin, over
// a valid/ready handshake. A resync pulse marks every field pending.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rom_bank..sys_reset     the 14 watched fields (indices 0x00..0x0D)
//   resync                  single-cycle pulse: dump all fields
//   tx_data/tx_valid        outgoing word and its valid flag
//   tx_ready                consumer accepts on tx_valid && tx_ready
// Parameter HOLDOFF: idle cycles forced after each accepted word.
module softsw_status_tx
  import softsw_pkg::*;
#(
  parameter int HOLDOFF = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rom_bank,
  input  logic        turbofdc,
  input  logic        covox_en,
  input  logic [1:0]  psg_mix,
  input  logic        psg_type,
  input  logic        video_15khz,
  input  logic [1:0]  turbo,
  input  logic        swap_fdd,
  input  logic [2:0]  joy_type,
  input  logic        nemoide_en,
  input  logic        keyboard_type,
  input  logic        pause,
  input  logic        nmi,
  input  logic        sys_reset,
  input  logic        resync,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int IW    = $clog2(NUM_FIELDS);
  localparam int GAP_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [VAL_W-1:0]      w_field_val [NUM_FIELDS];
  logic [VAL_W-1:0]      r_snap      [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] r_pending;
  logic [NUM_FIELDS-1:0] w_change;
  logic [NUM_FIELDS-1:0] w_set;
  logic [NUM_FIELDS-1:0] w_clr;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_any;
  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_next;
  logic                  w_load;
  logic                  w_valid_next;
  logic                  r_tx_valid;
  logic [15:0]           r_tx_data;

  // Field values in index order, zero-extended to the 8-bit value field.
  assign w_field_val = '{
    VAL_W'(rom_bank), VAL_W'(turbofdc), VAL_W'(covox_en), VAL_W'(psg_mix),
    VAL_W'(psg_type), VAL_W'(video_15khz), VAL_W'(turbo), VAL_W'(swap_fdd),
    VAL_W'(joy_type), VAL_W'(nemoide_en), VAL_W'(keyboard_type), VAL_W'(pause),
    VAL_W'(nmi), VAL_W'(sys_reset)
  };

  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    assign w_change[gi] = (w_field_val[gi] != r_snap[gi]);
    assign w_set[gi]    = w_change[gi] | resync;
    assign w_clr[gi]    = w_load && (w_pick_idx == IW'(gi));

    // The snapshot tracks the input with one cycle of delay; the reset load
    // and the normal update are the same assignment.
    always_ff @(posedge clk) begin
      r_snap[gi] <= w_field_val[gi];
    end
  end

  rr_pick #(
    .N  (NUM_FIELDS),
    .IW (IW)
  ) u_rr_pick (
    .i_pending (r_pending),
    .i_ptr     (r_rr_ptr),
    .o_any     (w_pick_any),
    .o_idx     (w_pick_idx)
  );

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    w_valid_next = r_tx_valid;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_load       = 1'b1;
          w_valid_next = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          w_valid_next = 1'b0;
          if (HOLDOFF == 0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_gap_next   = GAP_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
            w_state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_gap_next = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '1;
      r_rr_ptr   <= IW'(NUM_FIELDS - 1);
      r_state    <= ST_IDLE;
      r_gap      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      // A set on the load edge wins, so a field that changes while being
      // loaded is reported again with its newer value.
      r_pending  <= (r_pending & ~w_clr) | w_set;
      r_state    <= w_state_next;
      r_gap      <= w_gap_next;
      r_tx_valid <= w_valid_next;
      if (w_load) begin
        r_tx_data <= make_word(IDX_W'(w_pick_idx), r_snap[w_pick_idx]);
        r_rr_ptr  <= w_pick_idx;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_softsw_status_tx.sv
// Bench for softsw_status_tx: one instance with HOLDOFF=0 for the main
// directed sequence, one with HOLDOFF=4 for the inter-word gap checks.
module tb_softsw_status_tx;

  logic        clk = 1'b0;
  logic        reset, reset4;
  logic [1:0]  rom_bank;
  logic        turbofdc, covox_en;
  logic [1:0]  psg_mix;
  logic        psg_type, video_15khz;
  logic [1:0]  turbo;
  logic        swap_fdd;
  logic [2:0]  joy_type;
  logic        nemoide_en, keyboard_type, pause, nmi, sys_reset, resync;
  logic        tx_ready, tx_ready4;
  logic [15:0] tx_data0, tx_data4;
  logic        tx_valid0, tx_valid4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  softsw_status_tx #(.HOLDOFF(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .rom_bank(rom_bank), .turbofdc(turbofdc), .covox_en(covox_en),
    .psg_mix(psg_mix), .psg_type(psg_type), .video_15khz(video_15khz),
    .turbo(turbo), .swap_fdd(swap_fdd), .joy_type(joy_type),
    .nemoide_en(nemoide_en), .keyboard_type(keyboard_type), .pause(pause),
    .nmi(nmi), .sys_reset(sys_reset), .resync(resync),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready)
  );

  softsw_status_tx #(.HOLDOFF(4)) u_dut4 (
    .clk(clk), .reset(reset4),
    .rom_bank(rom_bank), .turbofdc(turbofdc), .covox_en(covox_en),
    .psg_mix(psg_mix), .psg_type(psg_type), .video_15khz(video_15khz),
    .turbo(turbo), .swap_fdd(swap_fdd), .joy_type(joy_type),
    .nemoide_en(nemoide_en), .keyboard_type(keyboard_type), .pause(pause),
    .nmi(nmi), .sys_reset(sys_reset), .resync(resync),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected value of field i from the bench's own input variables.
  function automatic logic [7:0] exp_val(input int i);
    case (i)
      0:  return 8'(rom_bank);
      1:  return 8'(turbofdc);
      2:  return 8'(covox_en);
      3:  return 8'(psg_mix);
      4:  return 8'(psg_type);
      5:  return 8'(video_15khz);
      6:  return 8'(turbo);
      7:  return 8'(swap_fdd);
      8:  return 8'(joy_type);
      9:  return 8'(nemoide_en);
      10: return 8'(keyboard_type);
      11: return 8'(pause);
      12: return 8'(nmi);
      13: return 8'(sys_reset);
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for a word that will be accepted on the next edge.
  task automatic wait_word0(input string tag, output logic [15:0] data);
    bit seen;
    seen = 1'b0;
    data = '0;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (tx_valid0 && tx_ready) begin
        seen = 1'b1;
        data = tx_data0;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    $display("dut0 %s word=%h", tag, data);
  endtask

  task automatic wait_word4(input string tag, output logic [15:0] data, output int gap);
    bit seen;
    seen = 1'b0;
    data = '0;
    gap  = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (tx_valid4 && tx_ready4) begin
        seen = 1'b1;
        data = tx_data4;
      end else if (!tx_valid4) begin
        gap++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    $display("dut4 %s word=%h gap=%0d", tag, data, gap);
  endtask

  task automatic check_dump0(input string tag);
    logic [15:0] w;
    for (int i = 0; i < 14; i++) begin
      wait_word0(tag, w);
      chk(tag, 32'(w), 32'({8'(i), exp_val(i)}));
    end
  endtask

  task automatic quiet0(input int n);
    int cnt;
    cnt = 0;
    for (int t = 0; t < n; t++) begin
      tick();
      if (tx_valid0) cnt++;
    end
    chk("quiet", 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          gap;
    int          errs;

    reset = 1'b1; reset4 = 1'b1;
    rom_bank = 2'd2; turbofdc = 0; covox_en = 0; psg_mix = 2'd0; psg_type = 0;
    video_15khz = 0; turbo = 2'd1; swap_fdd = 0; joy_type = 3'd0; nemoide_en = 0;
    keyboard_type = 0; pause = 0; nmi = 0; sys_reset = 0; resync = 0;
    tx_ready = 1'b1; tx_ready4 = 1'b1;

    repeat (3) tick();
    chk("rst_valid", 32'(tx_valid0), 32'd0);
    chk("rst_data", 32'(tx_data0), 32'h0000);

    // Post-reset dump in index order, then silence.
    reset = 1'b0;
    check_dump0("dump");
    quiet0(10);

    // Single change: pending at edge k, valid at edge k+1.
    turbo = 2'd2;
    tick();
    chk("turbo_lat", 32'(tx_valid0), 32'd0);
    tick();
    chk("turbo_valid", 32'(tx_valid0), 32'd1);
    chk("turbo_word", 32'(tx_data0), 32'h0602);
    quiet0(10);

    // Backpressure: word must hold steady while tx_ready is low.
    tx_ready = 1'b0;
    joy_type = 3'd5;
    tick();
    chk("bp_lat", 32'(tx_valid0), 32'd0);
    tick();
    chk("bp_valid", 32'(tx_valid0), 32'd1);
    chk("bp_word", 32'(tx_data0), 32'h0805);
    errs = 0;
    repeat (9) begin
      tick();
      if (!(tx_valid0 && tx_data0 == 16'h0805)) errs++;
    end
    chk("bp_hold", 32'(errs), 32'd0);
    tx_ready = 1'b1;
    tick();
    chk("bp_release", 32'(tx_valid0), 32'd0);
    quiet0(6);

    // Field re-changes on its own load edge: both values go out.
    pause = 1'b1;
    tick();
    chk("pause_lat", 32'(tx_valid0), 32'd0);
    pause = 1'b0;
    wait_word0("pause1", w);
    chk("pause_first", 32'(w), 32'h0B01);
    wait_word0("pause0", w);
    chk("pause_second", 32'(w), 32'h0B00);
    quiet0(6);

    // Round robin: after 0x05, 0x08 is nearer than 0x03.
    video_15khz = 1'b1;
    wait_word0("video", w);
    chk("video_word", 32'(w), 32'h0501);
    quiet0(4);
    psg_mix = 2'd3;
    joy_type = 3'd4;
    wait_word0("rr_a", w);
    chk("rr_first", 32'(w), 32'h0804);
    wait_word0("rr_b", w);
    chk("rr_second", 32'(w), 32'h0303);
    quiet0(6);

    // Reset while a word is stalled: word dropped, full dump follows.
    tx_ready = 1'b0;
    nmi = 1'b1;
    tick();
    tick();
    chk("rs_valid", 32'(tx_valid0), 32'd1);
    chk("rs_word", 32'(tx_data0), 32'h0C01);
    reset = 1'b1;
    tick();
    chk("rs_drop", 32'(tx_valid0), 32'd0);
    reset = 1'b0;
    tx_ready = 1'b1;
    check_dump0("redump");
    quiet0(6);

    // HOLDOFF=4 instance: reset dump, then a resync dump, gaps >= 4.
    reset4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wait_word4("hdump", w, gap);
      chk("hdump_word", 32'(w), 32'({8'(i), exp_val(i)}));
      if (i > 0) chk("hdump_gap", 32'(gap >= 4), 32'd1);
    end
    resync = 1'b1;
    tick();
    resync = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wait_word4("hsync", w, gap);
      chk("hsync_word", 32'(w), 32'({8'(i), exp_val(i)}));
      if (i > 0) chk("hsync_gap", 32'(gap >= 4), 32'd1);
    end
    errs = 0;
    repeat (12) begin
      tick();
      if (tx_valid4) errs++;
    end
    chk("h_quiet", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
